// File: rtl/bcd_countdown_timer_pkg.sv
// rtl/bcd_countdown_timer_pkg.sv - shared types, BCD limits and time packing for the countdown timer
package bcd_countdown_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PAUSED  = 2'd2,
        ST_EXPIRED = 2'd3
    } state_t;

    localparam logic [3:0] DIGIT_LIMIT = 4'd9;
    localparam logic [3:0] TENS_LIMIT  = 4'd5;

    localparam int SEC_ONES_LSB = 0;
    localparam int SEC_TENS_LSB = 4;
    localparam int MIN_ONES_LSB = 8;
    localparam int MIN_TENS_LSB = 12;

    // Nibble-wise BCD check; with valid nibbles the minutes byte compares like a number.
    function automatic logic time_is_valid(input logic [15:0] t, input logic [7:0] max_min);
        return (t[SEC_ONES_LSB +: 4] <= DIGIT_LIMIT) &&
               (t[SEC_TENS_LSB +: 4] <= TENS_LIMIT)  &&
               (t[MIN_ONES_LSB +: 4] <= DIGIT_LIMIT) &&
               (t[MIN_TENS_LSB +: 4] <= DIGIT_LIMIT) &&
               (t[MIN_ONES_LSB +: 8] <= max_min);
    endfunction

endpackage

// File: rtl/bcd_countdown_timer_digit.sv
// rtl/bcd_countdown_timer_digit.sv - one BCD down-counting digit with borrow out
module bcd_down_digit
    import bcd_countdown_timer_pkg::*;
#(
    parameter logic [3:0] LIMIT = DIGIT_LIMIT
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       en,
    input  logic       load,
    input  logic [3:0] load_val,
    output logic [3:0] digit,
    output logic       borrow
);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            digit <= 4'd0;
        end else if (load) begin
            digit <= load_val;
        end else if (en) begin
            digit <= (digit == 4'd0) ? LIMIT : digit - 4'd1;
        end
    end

    assign borrow = en && (digit == 4'd0);

endmodule

// File: rtl/bcd_countdown_timer.sv
// rtl/bcd_countdown_timer.sv - BCD mm:ss countdown timer with load, start/pause and expiry pulse
module bcd_countdown_timer
    import bcd_countdown_timer_pkg::*;
#(
    parameter int         TICK_DIV = 50_000_000,
    parameter logic [7:0] MAX_MIN  = 8'h59
) (
    input  logic        CLK,
    input  logic        CLRn,
    input  logic        Loadn,
    input  logic [15:0] D,
    input  logic        Start,
    input  logic        Pause,
    output logic [15:0] Q,
    output logic        Running,
    output logic        Done,
    output logic        Bo,
    output logic        LoadErr
);

    localparam int              PW       = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]   PRE_LAST = PW'(TICK_DIV - 1);

    state_t        state, state_next;
    logic [PW-1:0] prescaler;
    logic          load_req, load_ok, tick, at_one;
    logic [3:0]    en, bor;
    logic [15:0]   q_int;
    logic          min_tens_borrow_unused;

    assign load_req = !Loadn;
    assign load_ok  = load_req && time_is_valid(D, MAX_MIN);
    assign at_one   = (q_int == 16'h0001);
    // Any load or pause on this edge suppresses the decrement.
    assign tick     = Loadn && !Pause && (state == ST_RUN) && (prescaler == PRE_LAST);
    assign en       = {bor[2:0], tick};
    assign min_tens_borrow_unused = bor[3];

    bcd_down_digit #(.LIMIT(DIGIT_LIMIT)) u_sec_ones (
        .clk(CLK), .resetn(CLRn), .en(en[0]), .load(load_ok),
        .load_val(D[SEC_ONES_LSB +: 4]), .digit(q_int[SEC_ONES_LSB +: 4]), .borrow(bor[0])
    );
    bcd_down_digit #(.LIMIT(TENS_LIMIT)) u_sec_tens (
        .clk(CLK), .resetn(CLRn), .en(en[1]), .load(load_ok),
        .load_val(D[SEC_TENS_LSB +: 4]), .digit(q_int[SEC_TENS_LSB +: 4]), .borrow(bor[1])
    );
    bcd_down_digit #(.LIMIT(DIGIT_LIMIT)) u_min_ones (
        .clk(CLK), .resetn(CLRn), .en(en[2]), .load(load_ok),
        .load_val(D[MIN_ONES_LSB +: 4]), .digit(q_int[MIN_ONES_LSB +: 4]), .borrow(bor[2])
    );
    bcd_down_digit #(.LIMIT(DIGIT_LIMIT)) u_min_tens (
        .clk(CLK), .resetn(CLRn), .en(en[3]), .load(load_ok),
        .load_val(D[MIN_TENS_LSB +: 4]), .digit(q_int[MIN_TENS_LSB +: 4]), .borrow(bor[3])
    );

    always_ff @(posedge CLK) begin
        if (!CLRn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (load_req) begin
            if (load_ok) begin
                state_next = ST_IDLE;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    if (Start && !Pause && (q_int != 16'h0000)) begin
                        state_next = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (Pause) begin
                        state_next = ST_PAUSED;
                    end else if (tick && at_one) begin
                        state_next = ST_EXPIRED;
                    end
                end
                ST_PAUSED: begin
                    if (Start && !Pause) begin
                        state_next = ST_RUN;
                    end
                end
                default: state_next = state;
            endcase
        end
    end

    always_comb begin
        Running = (state == ST_RUN);
        Q       = q_int;
    end

    // Prescaler only advances in RUN; a pause freezes it so resume loses no count.
    always_ff @(posedge CLK) begin
        if (!CLRn) begin
            prescaler <= '0;
        end else if (load_ok) begin
            prescaler <= '0;
        end else if (!load_req) begin
            if ((state == ST_IDLE) && (state_next == ST_RUN)) begin
                prescaler <= '0;
            end else if ((state == ST_RUN) && !Pause) begin
                prescaler <= tick ? '0 : prescaler + PW'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!CLRn) begin
            Done    <= 1'b0;
            Bo      <= 1'b0;
            LoadErr <= 1'b0;
        end else begin
            Done    <= tick && at_one;
            Bo      <= bor[1];
            LoadErr <= load_req && !load_ok;
        end
    end

endmodule

// File: doc/bcd_countdown_timer.md
# bcd_countdown_timer

- Counts a BCD minutes:seconds value down to 00:00 at one step per second, then signals expiry.
- It is the down-counting counterpart of the team's BCD up-counter stages (mod-10 / mod-24 with carry out):
  - each digit pair counts down and borrows instead of counting up and carrying;
  - the result feeds the same 7-segment display path as the clock counters.
- A runtime load, start/pause control and a one-cycle done pulse let it serve as the kitchen-timer/alarm block of the lab clock design.

## Interface

Parameters:
- TICK_DIV, 50_000_000: CLK cycles per one-second decrement; legal range ≥ 2.
- MAX_MIN, 8'h59: largest legal minutes value loaded, in BCD.

Ports:
- CLK, input, 1: system clock; all state changes on its rising edge.
- CLRn, input, 1: reset, synchronous, active-low; clears all state.
- Loadn, input, 1: synchronous active-low load strobe for D.
- D, input, 16: load value, {min_tens, min_ones, sec_tens, sec_ones}, BCD.
- Start, input, 1: level-sampled request to begin or resume counting.
- Pause, input, 1: level-sampled request to suspend counting.
- Q, output, 16: current remaining time, BCD, same packing as D.
- Running, output, 1: high while in RUN.
- Done, output, 1: one-cycle pulse on expiry.
- Bo, output, 1: one-cycle pulse when seconds borrow from minutes (59 reload).
- LoadErr, output, 1: one-cycle pulse when a load is rejected.

## Operation

- Reset (CLRn=0 at an edge):
  - Q=16'h0000, state=IDLE, prescaler=0;
  - Running, Done, Bo and LoadErr all 0.
- Priority per edge: CLRn > Loadn > Pause > Start > tick.
- Load (Loadn=0):
  - D is valid only if every nibble ≤ 9, sec_tens ≤ 5 and minutes ≤ MAX_MIN.
  - Valid D: Q<=D, prescaler<=0, state<=IDLE.
  - Invalid D: Q unchanged, state unchanged, LoadErr=1 for one cycle.
  - Held Loadn re-loads every cycle.
- State machine:
  - IDLE: Start=1 and Q≠0 -> RUN with prescaler<=0. Start with Q=0 is ignored.
  - RUN: Pause=1 -> PAUSED, prescaler held. A tick decrements Q. If the tick decrements from 00:01 -> EXPIRED.
  - PAUSED: Start=1 and Pause=0 -> RUN, prescaler resumes from its held value.
  - EXPIRED: Q=0000. Start is ignored; only Load or CLRn leave EXPIRED (to IDLE).
- Decrement arithmetic, digit by digit with borrow:
  - sec_ones 0->9 with borrow; sec_tens 0->5 with borrow; min_ones 0->9 with borrow;
  - min_tens decrements on that borrow and never wraps, because 00:00 is terminal.
  - Bo pulses when the seconds pair goes 00->59.
- Q never holds a non-BCD value.

## Timing

- Prescaler counts 0..TICK_DIV-1 only in RUN. Tick = prescaler==TICK_DIV-1, and the prescaler wraps to 0 on that cycle.
- First decrement occurs TICK_DIV cycles after the edge that enters RUN.
- Q, Bo and Done are registered and update on the same edge as the tick.
  - Done=1 on exactly the edge where Q becomes 0000; Running falls on that same edge.
- Simultaneous events:
  - Pause with a tick: pause wins, no decrement.
  - Loadn with a tick: the load wins, no Done/Bo.
  - Start together with Pause in IDLE: stays IDLE.
- CLRn mid-run aborts immediately. No Done is generated.

## Structure

- Shared package:
  - state encoding IDLE/RUN/PAUSED/EXPIRED (2-bit);
  - BCD nibble limits (9, 5);
  - 16-bit time packing field offsets.
- One natural sub-module, bcd_down_digit:
  - parameter LIMIT (9 or 5);
  - inputs en, load, load value;
  - outputs digit and borrow (asserted when en and digit==0).
  - Instantiated four times in a borrow chain.
- The top holds the prescaler, FSM and load validation.

## Test plan

Use TICK_DIV=4 for simulation.

- Load D=16'h0003, Start -> Q steps 0003, 0002, 0001, 0000 at cycles 4/8/12 after Start. Done pulses with 0000. Running=0 thereafter.
- Load 16'h0100, Start -> after 4 cycles Q=16'h0059, Bo=1 for one cycle, Done=0.
- Load 16'h0010, run 2 cycles, Pause 10 cycles, Start -> first decrement (0009) lands 2 cycles after resume, with no loss of prescaler count.
- Load 16'h0A00, then 16'h0070, then (MAX_MIN=8'h30) 16'h4000 -> each gives LoadErr=1 and Q unchanged.
- Start with Q=0000 in IDLE -> stays IDLE, Running=0. Load 16'h0005 while in EXPIRED -> IDLE, Q=0005.
- CLRn=0 for one cycle mid-run at Q=0030 -> next cycle Q=0000, IDLE, all pulse outputs 0, no Done ever asserted.
